// File: rtl/jk_bank_hex_display.sv
// Bank of J-K flip-flops stepped by a slow-tick enable. The bank state (Q or its
// complement) is shown as hex digits on a multiplexed, active-low seven-segment display.
module jk_bank_hex_display #(
  parameter int CHANNELS = 8,
  parameter int DIV      = 4,
  parameter int SCAN_DIV = 2,
  localparam int NUM_DIGITS = (CHANNELS + 3) / 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [CHANNELS-1:0]   J,
  input  logic [CHANNELS-1:0]   K,
  input  logic                  Select,
  output logic [CHANNELS-1:0]   Q,
  output logic                  Tick,
  output logic [6:0]            HexValue,
  output logic [NUM_DIGITS-1:0] DigitEn
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PAD_W  = NUM_DIGITS * 4;

  logic [DIV_W-1:0]      divCnt;
  logic [SCAN_W-1:0]     scanCnt;
  logic [IDX_W-1:0]      digitIdx;
  logic [CHANNELS-1:0]   dispBits;
  logic [PAD_W-1:0]      dispPad;
  logic [3:0]            nibble;
  logic [6:0]            segs;
  logic [NUM_DIGITS-1:0] anodes;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      divCnt <= '0;
      Tick   <= 1'b0;
    end else begin
      Tick   <= (divCnt == DIV_W'(DIV - 1));
      divCnt <= (divCnt == DIV_W'(DIV - 1)) ? '0 : divCnt + 1'b1;
    end
  end

  // Per bit: JK=00 hold, 01 clear, 10 set, 11 toggle.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Q <= '0;
    end else if (Tick) begin
      Q <= (J & ~Q) | (~K & Q);
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      scanCnt  <= '0;
      digitIdx <= '0;
    end else if (scanCnt == SCAN_W'(SCAN_DIV - 1)) begin
      scanCnt  <= '0;
      digitIdx <= (digitIdx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digitIdx + 1'b1;
    end else begin
      scanCnt <= scanCnt + 1'b1;
    end
  end

  // Inversion covers only real channels; padding nibble bits stay 0.
  always_comb begin
    dispBits = Select ? ~Q : Q;
    dispPad  = PAD_W'(dispBits);
    nibble   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digitIdx == IDX_W'(i)) nibble = dispPad[i*4 +: 4];
    end
    anodes = ~(NUM_DIGITS'(1) << digitIdx);
  end

  always_comb begin
    segs = 7'h7F;
    case (nibble)
      4'h0: segs = 7'h40;
      4'h1: segs = 7'h79;
      4'h2: segs = 7'h24;
      4'h3: segs = 7'h30;
      4'h4: segs = 7'h19;
      4'h5: segs = 7'h12;
      4'h6: segs = 7'h02;
      4'h7: segs = 7'h78;
      4'h8: segs = 7'h00;
      4'h9: segs = 7'h10;
      4'hA: segs = 7'h08;
      4'hB: segs = 7'h03;
      4'hC: segs = 7'h46;
      4'hD: segs = 7'h21;
      4'hE: segs = 7'h06;
      4'hF: segs = 7'h0E;
      default: segs = 7'h7F;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      HexValue <= 7'h7F;
      DigitEn  <= '1;
    end else begin
      HexValue <= segs;
      DigitEn  <= anodes;
    end
  end

endmodule

// File: tb/tb_jk_bank_hex_display.sv
// Bench for jk_bank_hex_display: an 8-channel and a 6-channel instance share stimulus;
// an edge-count reference model feeds a scoreboard, plus directed display/reset checks.
module tb_jk_bank_hex_display;

  localparam int DIV = 4;
  localparam int SCAN_DIV = 2;

  logic       clk, rst, sel;
  logic [7:0] j, k;
  logic [7:0] q8;
  logic [5:0] q6;
  logic       tick8, tick6;
  logic [6:0] hex8, hex6;
  logic [1:0] en8, en6;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  typedef struct packed {
    logic [7:0] q8; logic tick8; logic [6:0] hex8; logic [1:0] en8;
    logic [5:0] q6; logic tick6; logic [6:0] hex6; logic [1:0] en6;
  } snap_t;

  snap_t expQ[$];
  snap_t obsQ[$];

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  jk_bank_hex_display #(.CHANNELS(8), .DIV(DIV), .SCAN_DIV(SCAN_DIV)) dut8 (
    .CLK(clk), .Reset(rst), .J(j), .K(k), .Select(sel),
    .Q(q8), .Tick(tick8), .HexValue(hex8), .DigitEn(en8));

  jk_bank_hex_display #(.CHANNELS(6), .DIV(DIV), .SCAN_DIV(SCAN_DIV)) dut6 (
    .CLK(clk), .Reset(rst), .J(j[5:0]), .K(k[5:0]), .Select(sel),
    .Q(q6), .Tick(tick6), .HexValue(hex6), .DigitEn(en6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", checks, fails);
    $fatal(1, "watchdog expired");
  end

  function automatic snap_t observed();
    return '{q8, tick8, hex8, en8, q6, tick6, hex6, en6};
  endfunction

  // Reference model: n counts rising edges since reset release.
  int unsigned n;
  int unsigned dig;
  logic [7:0]  mQ8, d8;
  logic [5:0]  mQ6, d6;
  snap_t       e;

  function automatic logic jkNext(input logic jb, input logic kb, input logic qb);
    case ({jb, kb})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~qb;
      default: return qb;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; mQ8 = '0; mQ6 = '0;
      expQ.delete(); obsQ.delete();
    end else begin
      n = n + 1;
      dig = ((n - 1) / SCAN_DIV) % 2;
      d8 = sel ? ~mQ8 : mQ8;
      d6 = sel ? ~mQ6 : mQ6;
      e.hex8 = SEG[dig ? d8[7:4] : d8[3:0]];
      e.hex6 = SEG[dig ? {2'b00, d6[5:4]} : d6[3:0]];
      e.en8  = dig ? 2'b01 : 2'b10;
      e.en6  = e.en8;
      if (n > 1 && (n - 1) % DIV == 0) begin
        for (int i = 0; i < 8; i++) mQ8[i] = jkNext(j[i], k[i], mQ8[i]);
        for (int i = 0; i < 6; i++) mQ6[i] = jkNext(j[i], k[i], mQ6[i]);
      end
      e.q8 = mQ8; e.q6 = mQ6;
      e.tick8 = (n % DIV == 0);
      e.tick6 = e.tick8;
      expQ.push_back(e);
    end
  end

  always @(negedge clk) if (!rst) obsQ.push_back(observed());

  task automatic test_reset();
    snap_t ex, ob;
    rst = 1'b1; j = '0; k = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({q8, tick8, hex8, en8} !== {8'h00, 1'b0, 7'h7F, 2'b11}) begin
      fails++; $display("FAIL reset_hold: got %h expected %h", {q8, tick8, hex8, en8}, {8'h00, 1'b0, 7'h7F, 2'b11});
    end
    #2 rst = 1'b0;
    for (int ed = 1; ed <= 12; ed++) begin
      @(negedge clk);
      checks++;
      if (tick8 !== (ed % DIV == 0)) begin
        fails++; $display("FAIL tick_period edge %0d: got %b expected %b", ed, tick8, ed % DIV == 0);
      end
    end
    j = 8'hFF;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (q8 !== 8'hFF) begin fails++; $display("FAIL pre_reset_set: got %h expected ff", q8); end
    checks++;
    if (expQ.size() != obsQ.size()) begin
      fails++; $display("FAIL sb_depth_reset: got %0d expected %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      ex = expQ.pop_front(); ob = obsQ.pop_front(); checks++;
      if (ob !== ex) begin fails++; $display("FAIL sb_reset: got %h expected %h", ob, ex); end
    end
    // Asynchronous assertion well away from any clock edge.
    @(posedge clk); #3 rst = 1'b1; #1;
    checks++;
    if ({q8, tick8, hex8, en8, q6, en6} !== {8'h00, 1'b0, 7'h7F, 2'b11, 6'h00, 2'b11}) begin
      fails++; $display("FAIL async_reset: got %h expected %h", {q8, tick8, hex8, en8, q6, en6},
                        {8'h00, 1'b0, 7'h7F, 2'b11, 6'h00, 2'b11});
    end
    j = '0;
    @(negedge clk); #2 rst = 1'b0;
    for (int ed = 1; ed <= 8; ed++) begin
      @(negedge clk);
      checks++;
      if (tick8 !== (ed % DIV == 0)) begin
        fails++; $display("FAIL tick_after_rerelease edge %0d: got %b expected %b", ed, tick8, ed % DIV == 0);
      end
    end
  endtask

  task automatic test_set();
    snap_t ex, ob;
    @(negedge clk); rst = 1'b1; j = 8'hFF; k = '0; sel = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    for (int ed = 1; ed <= 8; ed++) begin
      @(negedge clk);
      checks++;
      if ({q8, q6} !== ((ed >= 5) ? {8'hFF, 6'h3F} : 14'h0)) begin
        fails++; $display("FAIL set_from_reset edge %0d: got %h expected %h", ed, {q8, q6},
                          (ed >= 5) ? {8'hFF, 6'h3F} : 14'h0);
      end
    end
    #1;
    checks++;
    if (expQ.size() != obsQ.size()) begin
      fails++; $display("FAIL sb_depth_set: got %0d expected %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      ex = expQ.pop_front(); ob = obsQ.pop_front(); checks++;
      if (ob !== ex) begin fails++; $display("FAIL sb_set: got %h expected %h", ob, ex); end
    end
  endtask

  task automatic test_narrow();
    int unsigned t = 0;
    sel = 1'b0;
    do begin @(negedge clk); t++; end while (en6 !== 2'b01 && t < 8);
    checks++;
    if (hex6 !== 7'h30) begin fails++; $display("FAIL narrow_digit1_q: got %h expected 30", hex6); end
    @(negedge clk); @(negedge clk);
    checks++;
    if ({en6, hex6} !== {2'b10, 7'h0E}) begin
      fails++; $display("FAIL narrow_digit0_q: got %h expected %h", {en6, hex6}, {2'b10, 7'h0E});
    end
    sel = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({hex6, hex8} !== {7'h40, 7'h40}) begin
        fails++; $display("FAIL narrow_qbar cycle %0d: got %h expected %h", c, {hex6, hex8}, {7'h40, 7'h40});
      end
    end
  endtask

  task automatic test_clear();
    int unsigned t = 0;
    sel = 1'b0; j = '0; k = 8'hFF;
    do begin @(negedge clk); t++; end while (tick8 !== 1'b1 && t < 10);
    checks++;
    if (tick8 !== 1'b1) begin fails++; $display("FAIL clear_tick_wait: got %b expected 1", tick8); end
    @(negedge clk);
    checks++;
    if ({q8, q6} !== 14'h0) begin fails++; $display("FAIL clear: got %h expected 0000", {q8, q6}); end
  endtask

  task automatic test_toggle();
    snap_t ex, ob;
    logic [7:0] want [3] = '{8'hA5, 8'hAA, 8'hA5};
    int unsigned t;
    j = 8'hA5; k = 8'h5A;
    for (int s = 0; s < 3; s++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (tick8 !== 1'b1 && t < 10);
      checks++;
      if (tick8 !== 1'b1) begin fails++; $display("FAIL toggle_tick_wait %0d: got %b expected 1", s, tick8); end
      if (s > 0) begin
        checks++;
        if (q8 !== want[s-1]) begin
          fails++; $display("FAIL toggle_hold_between %0d: got %h expected %h", s, q8, want[s-1]);
        end
      end
      @(negedge clk);
      checks++;
      if (q8 !== want[s]) begin fails++; $display("FAIL toggle_step %0d: got %h expected %h", s, q8, want[s]); end
      j = 8'h0F; k = 8'h0F;
    end
    j = '0; k = '0;
    @(negedge clk); #1;
    checks++;
    if (expQ.size() != obsQ.size()) begin
      fails++; $display("FAIL sb_depth_toggle: got %0d expected %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      ex = expQ.pop_front(); ob = obsQ.pop_front(); checks++;
      if (ob !== ex) begin fails++; $display("FAIL sb_toggle: got %h expected %h", ob, ex); end
    end
  endtask

  task automatic test_display();
    logic [1:0] prev;
    int unsigned t = 0;
    sel = 1'b0;
    do begin prev = en8; @(negedge clk); t++; end while (!(prev === 2'b01 && en8 === 2'b10) && t < 10);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if ({hex8, en8} !== ((c < 2) ? {7'h12, 2'b10} : {7'h08, 2'b01})) begin
        fails++; $display("FAIL display_q cycle %0d: got %h expected %h", c, {hex8, en8},
                          (c < 2) ? {7'h12, 2'b10} : {7'h08, 2'b01});
      end
    end
  endtask

  task automatic test_select();
    snap_t ex, ob;
    logic [6:0] hx [7] = '{7'h08, 7'h08, 7'h12, 7'h12, 7'h08, 7'h12, 7'h08};
    logic [1:0] an [7] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
    logic [1:0] prev;
    int unsigned t = 0;
    sel = 1'b1;
    @(negedge clk);
    do begin prev = en8; @(negedge clk); t++; end while (!(prev === 2'b01 && en8 === 2'b10) && t < 10);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if ({hex8, en8} !== {hx[c], an[c]}) begin
        fails++; $display("FAIL select_qbar cycle %0d: got %h expected %h", c, {hex8, en8}, {hx[c], an[c]});
      end
      if (c == 4) sel = 1'b0;
    end
    #1;
    checks++;
    if (expQ.size() != obsQ.size()) begin
      fails++; $display("FAIL sb_depth_select: got %0d expected %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      ex = expQ.pop_front(); ob = obsQ.pop_front(); checks++;
      if (ob !== ex) begin fails++; $display("FAIL sb_select: got %h expected %h", ob, ex); end
    end
  endtask

  task automatic test_back_to_back();
    snap_t ex, ob;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      j = 8'($urandom); k = 8'($urandom);
      if ($urandom_range(3) == 0) sel = ~sel;
    end
    @(negedge clk); #1;
    checks++;
    if (expQ.size() != obsQ.size()) begin
      fails++; $display("FAIL sb_depth_random: got %0d expected %0d", obsQ.size(), expQ.size());
    end
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      ex = expQ.pop_front(); ob = obsQ.pop_front(); checks++;
      if (ob !== ex) begin fails++; $display("FAIL sb_random: got %h expected %h", ob, ex); end
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_narrow();
    test_clear();
    test_toggle();
    test_display();
    test_select();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
